vga_timing_generator: RTL and testbench
=======================================

# vga_timing_generator

Raster timing generator for the VGA output path: counts pixels and lines of a 640x480 @ 60 Hz frame on the 25 MHz pixel clock. It produces horizontal and vertical sync, an active-video flag, the current pixel coordinate, and a once-per-frame `screenEnd` pulse. The controller uses these to address image/sprite RAMs and to update game state between frames.

## Interface
- `WIDTH`, default 640: visible pixels per line.
- `HEIGHT`, default 480: visible lines per frame.
- `H_FRONT` = 16, `H_SYNC` = 96, `H_BACK` = 48: horizontal porch and sync lengths, in pixels.
- `V_FRONT` = 10, `V_SYNC` = 2, `V_BACK` = 33: vertical porch and sync lengths, in lines.
- `SYNC_ACTIVE`, default 0: level driven on `hSync`/`vSync` during the sync pulse. Default 0 means negative sync.
- Derived values: H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (525).

Ports (one clock; reset is asynchronous and active-low):
- `clk25`, in, 1: pixel clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `screenEnd`, out, 1: one-cycle pulse at the start of vertical blanking.
- `active`, out, 1: high while the counters are inside the visible WIDTH x HEIGHT window.
- `hSync`, out, 1: horizontal sync.
- `vSync`, out, 1: vertical sync.
- `x`, out, 10: current pixel column, 0..WIDTH-1.
- `y`, out, 9: current pixel row, 0..HEIGHT-1.

## Operation
- Internal `hCount` is 10 bits and runs 0..H_TOTAL-1. It increments every `clk25` and wraps to 0 after H_TOTAL-1.
- Internal `vCount` is 10 bits and runs 0..V_TOTAL-1. It increments only on the cycle where `hCount` wraps, and itself wraps to 0 after V_TOTAL-1.
- `active` = (`hCount` < WIDTH) & (`vCount` < HEIGHT).
- `x` = `hCount`[9:0] and `y` = `vCount`[8:0] while `active`. Both are forced to 0 when `active` is low, so any downstream RAM address stays within WIDTH*HEIGHT.
- `hSync` = SYNC_ACTIVE when `hCount` is in [WIDTH+H_FRONT, WIDTH+H_FRONT+H_SYNC), i.e. [656, 752). Otherwise it is ~SYNC_ACTIVE.
- `vSync` = SYNC_ACTIVE when `vCount` is in [HEIGHT+V_FRONT, HEIGHT+V_FRONT+V_SYNC), i.e. [490, 492). Otherwise it is ~SYNC_ACTIVE.
- `screenEnd` = (`hCount` == 0) & (`vCount` == HEIGHT). It is high for exactly one `clk25` cycle per frame.
- All outputs are combinational decodes of the two counter registers. There is no added pipeline stage, and no output glitches back-to-back between counter states.
- Width rule: all compares use zero-extended 10-bit counters. The parameters are assumed to fit in 10 bits (H_TOTAL, V_TOTAL ≤ 1023).

## Timing
- Reset asserted (`reset` = 0):
  - `hCount` and `vCount` clear to 0 immediately, with no clock required.
  - Outputs while in reset: `active` = 1, `x` = 0, `y` = 0, `hSync` = `vSync` = ~SYNC_ACTIVE (1 by default), `screenEnd` = 0.
- Reset deassertion: the first rising edge of `clk25` after release moves `hCount` to 1. Counting is synchronous from then on.
- Reset mid-frame: the frame aborts immediately and restarts at pixel (0,0), with no partial sync pulse completed.
- Line period is 800 cycles: 640 active, then 16 front porch, 96 sync, 48 back porch.
- Frame period is 525 lines, i.e. 420000 cycles.
- `screenEnd` rises 384000 cycles after the frame origin (`hCount` = `vCount` = 0).
- Wrap corner (`hCount` = 799 and `vCount` = 524): the next edge clears both counters to 0, `active` returns to 1, and `x` = `y` = 0.
- Consumer note: `screenEnd` is a single `clk25` cycle. A consumer sampling on a faster clock must edge-detect the pulse if it wants one action per frame.

## Test plan
- Reset check: hold `reset` = 0, toggle `clk25` 10 times. Expect `x` = 0, `y` = 0, `active` = 1, `hSync` = 1, `vSync` = 1, `screenEnd` = 0 throughout.
- Horizontal timing: after release, count cycles on line 0.
  - `active` is high for 640 cycles.
  - `hSync` goes low at `hCount` 656 and high again at 752.
  - `x` reads 639 on the last active pixel, then 0.
- Vertical timing:
  - `vSync` is low only for lines 490-491 (1600 cycles).
  - `y` reaches 479, then reads 0 during blanking.
  - `active` stays low for all of lines 480-524.
- Frame pulse: over 3 full frames (1260000 cycles), `screenEnd` pulses exactly 3 times, each 1 cycle wide and 420000 cycles apart. The first pulse is at cycle 384000 after release.
- Wrap: at `hCount` 799 / `vCount` 524, the next edge gives `active` = 1, `x` = 0, `y` = 0, and the sync pattern repeats identically.
- Mid-frame reset: assert `reset` at line 300 pixel 100 without a clock edge. Outputs go to reset values at once. After release, the first `screenEnd` again occurs 384000 cycles later.

Source files
------------

// File: rtl/vga_timing_generator.sv
// -----------------------------------------------------------------------------
// vga_timing_generator
// Raster timing for a VGA output path (640x480 @ 60 Hz on a 25 MHz pixel
// clock by default). Two free-running counters (pixel within line, line within
// frame) are decoded combinationally into sync, active-video, pixel coordinate
// and an end-of-visible-frame pulse.
//
// Ports:
//   clk25     in   pixel clock, all state changes on its rising edge
//   reset     in   asynchronous, active-low reset (counters clear at once)
//   screenEnd out  one-cycle pulse at the first pixel of vertical blanking
//   active    out  high inside the visible WIDTH x HEIGHT window
//   hSync     out  horizontal sync, SYNC_ACTIVE during the pulse
//   vSync     out  vertical sync, SYNC_ACTIVE during the pulse
//   x         out  pixel column while active, 0 otherwise
//   y         out  pixel row while active, 0 otherwise
// -----------------------------------------------------------------------------
module vga_timing_generator #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       screenEnd,
  output logic       active,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam int unsigned H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  // All decode constants held as 10-bit values so every compare is 10 vs 10.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(WIDTH);
  localparam logic [9:0] V_VIS    = 10'(HEIGHT);
  localparam logic [9:0] HS_START = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(HEIGHT + V_FRONT + V_SYNC);

  logic [9:0] r_hCount;
  logic [9:0] r_vCount;
  logic       w_hWrap;
  logic       w_vWrap;
  logic       w_active;
  logic       w_hSyncOn;
  logic       w_vSyncOn;

  assign w_hWrap = (r_hCount == H_LAST);
  assign w_vWrap = (r_vCount == V_LAST);

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      r_hCount <= '0;
      r_vCount <= '0;
    end else begin
      if (w_hWrap) begin
        r_hCount <= '0;
        // Line counter advances only on the pixel counter's wrap cycle.
        if (w_vWrap) begin
          r_vCount <= '0;
        end else begin
          r_vCount <= r_vCount + 10'd1;
        end
      end else begin
        r_hCount <= r_hCount + 10'd1;
      end
    end
  end

  always_comb begin
    w_active  = (r_hCount < H_VIS) && (r_vCount < V_VIS);
    w_hSyncOn = (r_hCount >= HS_START) && (r_hCount < HS_END);
    w_vSyncOn = (r_vCount >= VS_START) && (r_vCount < VS_END);

    active    = w_active;
    hSync     = w_hSyncOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vSync     = w_vSyncOn ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    screenEnd = (r_hCount == '0) && (r_vCount == V_VIS);
    // Coordinates are zeroed in blanking so RAM addresses stay in the frame.
    x         = w_active ? r_hCount      : '0;
    y         = w_active ? r_vCount[8:0] : '0;
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_generator
// Two instances share clock and reset: "s" uses a shrunken raster so whole
// frames fit in a short run, "d" uses the default 640x480 timing for line-level
// checks. Expected values are computed by hand for each instance.
//
// Small raster: WIDTH=8 H_FRONT=2 H_SYNC=3 H_BACK=2 -> H_TOTAL=15,
//               hSync low for h in [10,13)
//               HEIGHT=6 V_FRONT=1 V_SYNC=2 V_BACK=2 -> V_TOTAL=11,
//               vSync low for v in [7,9)
//               frame = 165 cycles, screenEnd at cycle 6*15 = 90.
// t = rising edges since reset release, so h = t mod 15, v = (t/15) mod 11.
// -----------------------------------------------------------------------------
module tb_vga_timing_generator;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;

  logic       s_se, s_act, s_hs, s_vs;
  logic [9:0] s_x;
  logic [8:0] s_y;
  logic       d_se, d_act, d_hs, d_vs;
  logic [9:0] d_x;
  logic [8:0] d_y;

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;

  always #5 clk25 = ~clk25;

  vga_timing_generator #(
    .WIDTH(8), .HEIGHT(6),
    .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b0)
  ) u_small (
    .clk25(clk25), .reset(reset),
    .screenEnd(s_se), .active(s_act), .hSync(s_hs), .vSync(s_vs),
    .x(s_x), .y(s_y)
  );

  vga_timing_generator u_dflt (
    .clk25(clk25), .reset(reset),
    .screenEnd(d_se), .active(d_act), .hSync(d_hs), .vSync(d_vs),
    .x(d_x), .y(d_y)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input int act, input int xx, input int yy,
                       input int hs, input int vs, input int se);
    check({tag, ".s_active"}, 32'(s_act), 32'(act));
    check({tag, ".s_x"},      32'(s_x),   32'(xx));
    check({tag, ".s_y"},      32'(s_y),   32'(yy));
    check({tag, ".s_hSync"},  32'(s_hs),  32'(hs));
    check({tag, ".s_vSync"},  32'(s_vs),  32'(vs));
    check({tag, ".s_scrEnd"}, 32'(s_se),  32'(se));
  endtask

  task automatic chk_d(input string tag, input int act, input int xx, input int yy,
                       input int hs, input int vs, input int se);
    check({tag, ".d_active"}, 32'(d_act), 32'(act));
    check({tag, ".d_x"},      32'(d_x),   32'(xx));
    check({tag, ".d_y"},      32'(d_y),   32'(yy));
    check({tag, ".d_hSync"},  32'(d_hs),  32'(hs));
    check({tag, ".d_vSync"},  32'(d_vs),  32'(vs));
    check({tag, ".d_scrEnd"}, 32'(d_se),  32'(se));
  endtask

  // Advance to edge count 'target' and sample 1 time unit after that edge.
  task automatic adv_to(input int target);
    repeat (target - t) @(posedge clk25);
    #1;
    t = target;
  endtask

  initial begin
    int pulses;
    int d_pulses;
    int pos [3];

    // Reset held across 10 clock edges: outputs pinned to reset values.
    #2 reset = 1'b0;
    #1;
    chk_s("rst_async", 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk25);
      #1;
      chk_s("rst_hold", 1, 0, 0, 1, 1, 0);
      chk_d("rst_hold", 1, 0, 0, 1, 1, 0);
    end

    // Release away from the clock edge; counters are at (0,0).
    reset = 1'b1;
    t = 0;
    #1;
    chk_s("t0", 1, 0, 0, 1, 1, 0);
    adv_to(1);   check("t1.s_x", 32'(s_x), 32'd1);
                 check("t1.d_x", 32'(d_x), 32'd1);
    adv_to(7);   chk_s("t7",   1, 7, 0, 1, 1, 0);
    adv_to(8);   chk_s("t8",   0, 0, 0, 1, 1, 0);
    adv_to(9);   chk_s("t9",   0, 0, 0, 1, 1, 0);
    adv_to(10);  chk_s("t10",  0, 0, 0, 0, 1, 0);
    adv_to(12);  chk_s("t12",  0, 0, 0, 0, 1, 0);
    adv_to(13);  chk_s("t13",  0, 0, 0, 1, 1, 0);
    adv_to(14);  chk_s("t14",  0, 0, 0, 1, 1, 0);
    adv_to(15);  chk_s("t15",  1, 0, 1, 1, 1, 0);
    adv_to(82);  chk_s("t82",  1, 7, 5, 1, 1, 0);
    adv_to(89);  chk_s("t89",  0, 0, 0, 1, 1, 0);
    adv_to(90);  chk_s("t90",  0, 0, 0, 1, 1, 1);
    adv_to(91);  chk_s("t91",  0, 0, 0, 1, 1, 0);
    adv_to(105); chk_s("t105", 0, 0, 0, 1, 0, 0);
    adv_to(134); chk_s("t134", 0, 0, 0, 1, 0, 0);
    adv_to(135); chk_s("t135", 0, 0, 0, 1, 1, 0);
    adv_to(164); chk_s("t164", 0, 0, 0, 1, 1, 0);
    adv_to(165); chk_s("t165_wrap", 1, 0, 0, 1, 1, 0);
    adv_to(175); chk_s("t175", 0, 0, 0, 0, 1, 0);
    adv_to(255); chk_s("t255", 0, 0, 0, 1, 1, 1);

    // Default 640x480 instance, line 0 and start of line 1.
    adv_to(639); chk_d("d639", 1, 639, 0, 1, 1, 0);
    adv_to(640); chk_d("d640", 0, 0, 0, 1, 1, 0);
    adv_to(655); chk_d("d655", 0, 0, 0, 1, 1, 0);
    adv_to(656); chk_d("d656", 0, 0, 0, 0, 1, 0);
    adv_to(751); chk_d("d751", 0, 0, 0, 0, 1, 0);
    adv_to(752); chk_d("d752", 0, 0, 0, 1, 1, 0);
    adv_to(799); chk_d("d799", 0, 0, 0, 1, 1, 0);
    adv_to(800); chk_d("d800", 1, 0, 1, 1, 1, 0);

    // Mid-frame: small at v=7,h=11 (both syncs low), default at h=141,v=1.
    adv_to(941);
    chk_s("t941", 0, 0, 0, 0, 0, 0);
    chk_d("t941", 1, 141, 1, 1, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk_s("mid_rst", 1, 0, 0, 1, 1, 0);
    chk_d("mid_rst", 1, 0, 0, 1, 1, 0);
    repeat (2) @(posedge clk25);
    #1;
    chk_s("mid_rst_hold", 1, 0, 0, 1, 1, 0);
    reset = 1'b1;
    t = 0;

    // Three small frames after release: pulses at 90, 255, 420, one cycle each.
    pulses   = 0;
    d_pulses = 0;
    pos      = '{-1, -1, -1};
    for (int i = 1; i <= 495; i++) begin
      @(posedge clk25);
      #1;
      if (s_se === 1'b1) begin
        if (pulses < 3) pos[pulses] = i;
        pulses++;
      end
      if (d_se !== 1'b0) d_pulses++;
    end
    check("s_pulse_count",  32'(pulses),   32'd3);
    check("s_pulse0_cycle", 32'(pos[0]),   32'd90);
    check("s_pulse1_cycle", 32'(pos[1]),   32'd255);
    check("s_pulse2_cycle", 32'(pos[2]),   32'd420);
    check("d_no_pulse",     32'(d_pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
